load_store_unit: RTL and testbench

- Sits directly downstream of the control decoder and the ALU in the RV32I core.
- Consumes the memory-control fields memread, memwrite, memsize and mem_signed_load, plus the ALU address and the rs2 store data.
- Performs the access over a request/grant/response data bus and returns the sign/zero-extended load result for writeback.
- Asserts stall to freeze the PC while an access is in flight.

---
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I load/store unit driving a req/gnt/rvalid data bus, with
//            byte-lane steering, load extension, bus timeout and PC stall.
//            Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [1:0]        memsize,
    input  logic              mem_signed_load,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [1:0]       r_size;
    logic             r_signed;
    logic [1:0]       r_off;
    logic [CNT_W-1:0] r_cnt;

    logic             w_access;
    logic             w_misalign;
    logic             w_timeout;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;

    assign w_access  = memread | memwrite;
    assign w_timeout = (MAX_WAIT > 0) && (r_cnt == c_cnt_last);
    assign stall     = ((r_state == S_IDLE) && w_access) ||
                       (r_state == S_REQ) || (r_state == S_WAIT);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((memsize == 2'b01) && addr[0]) ||
                        (memsize[1] && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Store lane steering: enables follow the size, data replicated across lanes
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        case (memsize)
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = bus_rdata[7:0];
        case (r_off)
            2'd0:    w_byte = bus_rdata[7:0];
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_size    <= 2'b00;
            r_signed  <= 1'b0;
            r_off     <= 2'b00;
            r_cnt     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'd0;
            rdata     <= 32'd0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_size    <= memsize;
                        r_signed  <= mem_signed_load;
                        r_off     <= addr[1:0];
                        r_cnt     <= '0;
                        bus_we    <= memwrite & ~memread;
                        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        bus_be    <= w_be;
                        bus_wdata <= w_wdata;
                        if (w_misalign) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            rdata   <= 32'd0;
                        end else begin
                            r_state <= S_REQ;
                            bus_req <= 1'b1;
                            err     <= 1'b0;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        if (bus_we) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else if (w_timeout) begin
                        bus_req <= 1'b0;
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= 32'd0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus_rvalid) begin
                        rdata   <= w_load;
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= 32'd0;
                    end
                end
                // The instruction retires on this edge; its controls are not re-sampled
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit with a reactive bus
//            model and a byte-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam int MAXW = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memread, memwrite, mem_signed_load;
    logic [1:0]  memsize;
    logic [31:0] addr, wdata;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .memread(memread), .memwrite(memwrite), .memsize(memsize),
        .mem_signed_load(mem_signed_load), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .done(done), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Offset of the accessed item inside its word, aligned down to its size
    function automatic int item_off(input logic [1:0] sz, input logic [31:0] a);
        int nb;
        nb = nbytes(sz);
        return (int'(a % 4) / nb) * nb;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be;
        int off, nb;
        nb  = nbytes(sz);
        off = item_off(sz, a);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nb);
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] v;
        int nb;
        nb = nbytes(sz);
        for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % nb) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit sg,
                                             input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v, mask;
        int nb;
        nb   = nbytes(sz);
        v    = rd >> (8 * item_off(sz, a));
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = v & mask;
        if (sg && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (nbytes(sz) > 1) && ((a % nbytes(sz)) != 0);
`else
        return (sz === 2'bxx) && (a === 32'hx);
`endif
    endfunction

    // One complete access; cycle 0 is the request cycle, bus model reacts per cycle
    task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdat);
        int  need, done_cyc, gnt_cyc, rv_cyc;
        bit  mis, tmo, exp_req;
        mis     = ref_misaligned(sz, a);
        need    = rd ? (gnt_dly + rv_dly + 2) : (gnt_dly + 1);
        tmo     = !mis && (need > MAXW);
        done_cyc = mis ? 1 : (tmo ? MAXW + 1 : need + 1);
        gnt_cyc = 1 + gnt_dly;
        rv_cyc  = gnt_cyc + 1 + rv_dly;

        @(negedge clk);
        memread = rd; memwrite = wr; memsize = sz; mem_signed_load = sg;
        addr = a; wdata = wd; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = rdat;
        #1 chk("stall_req_cycle", 32'(stall), 32'd1);

        for (int cyc = 1; cyc <= done_cyc; cyc++) begin
            @(negedge clk);
            bus_gnt    = (cyc == gnt_cyc);
            bus_rvalid = rd && (cyc == rv_cyc);
            exp_req    = !mis && (cyc < done_cyc) && (cyc <= gnt_cyc);
            chk("bus_req", 32'(bus_req), 32'(exp_req));
            chk("stall", 32'(stall), 32'(cyc < done_cyc));
            chk("done", 32'(done), 32'(cyc == done_cyc));
            if (exp_req && cyc == 1) begin
                chk("bus_addr", bus_addr, {a[31:2], 2'b00});
                chk("bus_be", 32'(bus_be), 32'(ref_be(sz, a)));
                chk("bus_we", 32'(bus_we), 32'(wr && !rd));
                if (wr && !rd) chk("bus_wdata", bus_wdata, ref_wdata(sz, wd));
            end
            if (cyc == done_cyc) begin
                chk("err", 32'(err), 32'(mis || tmo));
                if (rd) chk("rdata", rdata, (mis || tmo) ? 32'd0 : ref_load(sz, sg, a, rdat));
            end
        end
        // Controls are still high in DONE; they must not restart an access
        @(posedge clk);
        #1;
        memread = 1'b0; memwrite = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        chk("idle_bus_req", 32'(bus_req), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        bit rd, wr;
        int gd, rvd;
        rst_n = 1'b0; memread = 1'b0; memwrite = 1'b0; memsize = 2'b00;
        mem_signed_load = 1'b0; addr = 32'd0; wdata = 32'd0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        access(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
        access(1, 0, 2'b00, 1, 32'h103, 32'h0, 0, 0, 32'h80123456);
        access(1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 0, 32'h80123456);
        access(0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 4, 0, 32'h0);
        access(1, 0, 2'b10, 0, 32'h100, 32'h0, 100, 0, 32'h55AA55AA);
        access(1, 0, 2'b10, 0, 32'h104, 32'h0, 3, 12, 32'h11223344);
        access(1, 0, 2'b10, 0, 32'h104, 32'h0, 3, 11, 32'h11223344);
        access(1, 0, 2'b10, 0, 32'h101, 32'h0, 0, 0, 32'hCAFEF00D);
        access(1, 1, 2'b01, 1, 32'h106, 32'h0, 1, 1, 32'hF00D1234);

        // Reset while WAIT: bus_req drops, the late response is ignored
        @(negedge clk);
        memread = 1'b1; memsize = 2'b10; addr = 32'h300; bus_rdata = 32'h12345678;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0; memread = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; bus_rvalid = 1'b1;
        chk("rstw_bus_req", 32'(bus_req), 32'd0);
        chk("rstw_stall", 32'(stall), 32'd0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("rstw_done", 32'(done), 32'd0);
        chk("rstw_rdata", rdata, 32'd0);
        chk("rstw_err", 32'(err), 32'd0);

        for (int k = 0; k < 40; k++) begin
            rd  = $urandom_range(0, 1) == 1;
            wr  = !rd || ($urandom_range(0, 3) == 0);
            gd  = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
            rvd = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 4);
            access(rd, wr, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                   $urandom, $urandom, gd, rvd, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
